// File: rtl/spi_flash_rd_seq.sv
// spi_flash_rd_seq
//   APB master sequencer that runs a complete serial-flash read on an SPI
//   master's APB register port: it programs CLKDIV, SPICMD, SPIADR, SPILEN,
//   SPIDUM and STATUS(go), then polls STATUS and drains RXFIFO one word at a
//   time onto a valid/ready response stream.
//
// Ports
//   HCLK, HRESET                      clock, synchronous active-high reset
//   req_valid/req_ready               request handshake
//   req_addr[23:0], req_words[10:0]   flash byte address, 32-bit word count
//   req_clkdiv[7:0]                   SPI clock divider
//   rsp_valid/rsp_ready               response handshake
//   rsp_data[31:0], rsp_last          read word, final word of the request
//   busy                              transaction in progress
//   PADDR..PENABLE, PRDATA, PREADY    APB master port
//   PSLVERR                           APB error (used only with timeout build)
//   err                               abort pulse (timeout build only)
//
// Build option
//   SPI_SEQ_TIMEOUT_EN : adds TIMEOUT_CYCLES, a poll counter and the err
//   output; a poll timeout or PSLVERR aborts with a STATUS soft-reset write.
module spi_flash_rd_seq #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter logic [7:0]  READ_CMD       = 8'h03,
  parameter logic [3:0]  CS_MASK        = 4'b0001,
  parameter int unsigned MAX_WORDS      = 2047
`ifdef SPI_SEQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [23:0]               req_addr,
  input  logic [10:0]               req_words,
  input  logic [7:0]                req_clkdiv,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_data,
  output logic                      rsp_last,
  output logic                      busy,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
`ifdef SPI_SEQ_TIMEOUT_EN
  , output logic                    err
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_CLKDIV, S_WR_CMD, S_WR_ADR, S_WR_LEN, S_WR_DUM, S_WR_GO,
    S_POLL, S_RD_RX, S_PUSH, S_ABORT
  } state_t;

  state_t      r_state;
  logic [23:0] r_addr;
  logic [10:0] r_words;
  logic [10:0] r_remaining;
  logic        w_abort;

`ifdef SPI_SEQ_TIMEOUT_EN
  logic [15:0] r_poll_cnt;
  assign w_abort = (PSLVERR && r_state != S_ABORT) ||
                   (r_state == S_POLL && PRDATA[20:16] == '0 &&
                    32'(r_poll_cnt) >= TIMEOUT_CYCLES);
`else
  logic w_unused_pslverr;
  assign w_unused_pslverr = PSLVERR;
  assign w_abort          = 1'b0;
`endif

  // Enter an APB state in its SETUP phase with the access fields loaded.
  task automatic apb_start(input state_t s, input logic [5:0] a,
                           input logic [31:0] d, input logic w);
    r_state <= s;
    PSEL    <= 1'b1;
    PENABLE <= 1'b0;
    PADDR   <= APB_ADDR_WIDTH'(a);
    PWDATA  <= d;
    PWRITE  <= w;
  endtask

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= S_IDLE;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_last    <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      r_addr      <= '0;
      r_words     <= '0;
      r_remaining <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
      r_poll_cnt  <= '0;
      err         <= 1'b0;
`endif
    end else begin
`ifdef SPI_SEQ_TIMEOUT_EN
      err <= 1'b0;
      if (r_state == S_POLL && r_poll_cnt != '1)
        r_poll_cnt <= r_poll_cnt + 16'd1;
`endif
      case (r_state)
        S_IDLE: begin
`ifdef SPI_SEQ_TIMEOUT_EN
          r_poll_cnt <= '0;
`endif
          // Zero or oversized requests are consumed here without any traffic.
          if (req_valid && req_words != '0 && 32'(req_words) <= MAX_WORDS) begin
            r_addr      <= req_addr;
            r_words     <= req_words;
            r_remaining <= req_words;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            apb_start(S_WR_CLKDIV, 6'h04, {24'h0, req_clkdiv}, 1'b1);
          end
        end
        S_PUSH: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            // Terminal check before decrement keeps the counter from wrapping.
            if (r_remaining == 11'd1) begin
              r_state   <= S_IDLE;
              req_ready <= 1'b1;
              busy      <= 1'b0;
            end else begin
              r_remaining <= r_remaining - 11'd1;
              apb_start(S_POLL, 6'h00, '0, 1'b0);
            end
          end
        end
        default: begin
          if (!PENABLE) begin
            PENABLE <= 1'b1;
          end else if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            if (w_abort) begin
              apb_start(S_ABORT, 6'h00, 32'h10, 1'b1);
            end else begin
              case (r_state)
                S_WR_CLKDIV: apb_start(S_WR_CMD, 6'h08, {READ_CMD, 24'h0}, 1'b1);
                S_WR_CMD:    apb_start(S_WR_ADR, 6'h0C, {r_addr, 8'h00}, 1'b1);
                S_WR_ADR:    apb_start(S_WR_LEN, 6'h10,
                                       {r_words, 5'b0, 2'b0, 6'd24, 2'b0, 6'd8}, 1'b1);
                S_WR_LEN:    apb_start(S_WR_DUM, 6'h14, '0, 1'b1);
                S_WR_DUM:    apb_start(S_WR_GO, 6'h00, {20'h0, CS_MASK, 8'h01}, 1'b1);
                S_WR_GO:     apb_start(S_POLL, 6'h00, '0, 1'b0);
                S_POLL: begin
                  if (PRDATA[20:16] != '0) begin
                    apb_start(S_RD_RX, 6'h20, '0, 1'b0);
`ifdef SPI_SEQ_TIMEOUT_EN
                    r_poll_cnt <= '0;
`endif
                  end else begin
                    apb_start(S_POLL, 6'h00, '0, 1'b0);
                  end
                end
                S_RD_RX: begin
                  rsp_data  <= PRDATA;
                  rsp_valid <= 1'b1;
                  rsp_last  <= (r_remaining == 11'd1);
                  r_state   <= S_PUSH;
                end
                S_ABORT: begin
`ifdef SPI_SEQ_TIMEOUT_EN
                  err <= 1'b1;
`endif
                  r_state   <= S_IDLE;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                end
                default: r_state <= S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
module tb_spi_flash_rd_seq;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic [10:0] req_words;
  logic [7:0]  req_clkdiv;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        busy;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  spi_flash_rd_seq #(.APB_ADDR_WIDTH(12), .READ_CMD(8'h03), .CS_MASK(4'b0001),
                     .MAX_WORDS(2047)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_words(req_words), .req_clkdiv(req_clkdiv),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .busy(busy),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic        wr;
    logic [11:0] a;
    logic [31:0] d;
  } apb_t;

  // ---------------- APB slave model (completed accesses are logged) -------
  int unsigned wait_cfg = 0;
  int unsigned zero_cfg = 0;
  logic [31:0] rx_mem [4096];
  int unsigned rx_idx   = 0;
  int unsigned unstable = 0;
  apb_t        log_q[$];
  int unsigned wcnt = 0;
  int unsigned zcnt = 0;
  logic [11:0] s_addr;
  logic [31:0] s_data;
  logic        s_wr;

  always @(negedge HCLK) begin
    if (PSEL && !PENABLE) begin
      s_addr = PADDR; s_data = PWDATA; s_wr = PWRITE; wcnt = 0; PREADY = 1'b0;
    end else if (PSEL && PENABLE) begin
      if (PADDR !== s_addr || PWDATA !== s_data || PWRITE !== s_wr) unstable++;
      if (wcnt < wait_cfg) begin
        wcnt++;
        PREADY = 1'b0;
      end else begin
        PREADY = 1'b1;
        if (!PWRITE) begin
          if (PADDR[5:0] == 6'h00) begin
            if (zcnt < zero_cfg) begin
              zcnt++;
              PRDATA = $urandom & 32'hFFE0_FFFF;
            end else begin
              zcnt = 0;
              PRDATA = ($urandom & 32'hFFE0_FFFF) | (32'($urandom_range(1, 31)) << 16);
            end
          end else if (PADDR[5:0] == 6'h20) begin
            PRDATA = rx_mem[rx_idx % 4096];
            rx_idx++;
          end else begin
            PRDATA = $urandom;
          end
        end
        log_q.push_back('{wr: PWRITE, a: PADDR, d: (PWRITE ? PWDATA : 32'h0)});
      end
    end else begin
      PREADY = 1'b0;
    end
  end

  // ---------------- checking ----------------------------------------------
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [23:0] a, input logic [10:0] w, input logic [7:0] cd);
    chk("ready_before_req", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_addr = a; req_words = w; req_clkdiv = cd;
    @(negedge HCLK);
    req_valid = 1'b0;
  endtask

  // Full request: expected APB sequence and data come from the read protocol,
  // not from the design's internal states.
  task automatic run_req(input logic [23:0] a, input int unsigned w, input logic [7:0] cd,
                         input int unsigned ws, input int unsigned zp,
                         input int unsigned stall_w, input int unsigned stall_n,
                         input bit use_d0, input logic [31:0] d0);
    apb_t        exp_q[$];
    logic [31:0] ed[$];
    int unsigned base_log;
    int unsigned base_rx;
    logic [31:0] v;
    logic [31:0] held;
    bit          ok;
    wait_cfg = ws; zero_cfg = zp;
    base_log = log_q.size();
    base_rx  = rx_idx;
    for (int i = 0; i < int'(w); i++) begin
      v = (use_d0 && i == 0) ? d0 : $urandom;
      ed.push_back(v);
      rx_mem[(base_rx + i) % 4096] = v;
    end
    exp_q.push_back('{1'b1, 12'h004, {24'h0, cd}});
    exp_q.push_back('{1'b1, 12'h008, 32'h0300_0000});
    exp_q.push_back('{1'b1, 12'h00C, {a, 8'h00}});
    exp_q.push_back('{1'b1, 12'h010, (((w * 32) & 32'hFFFF) << 16) | (24 << 8) | 8});
    exp_q.push_back('{1'b1, 12'h014, 32'h0});
    exp_q.push_back('{1'b1, 12'h000, 32'h0000_0101});
    for (int i = 0; i < int'(w); i++) begin
      for (int p = 0; p <= int'(zp); p++) exp_q.push_back('{1'b0, 12'h000, 32'h0});
      exp_q.push_back('{1'b0, 12'h020, 32'h0});
    end

    start_req(a, 11'(w), cd);
    chk("busy_after_accept", 64'(busy), 64'd1);
    chk("ready_after_accept", 64'(req_ready), 64'd0);

    for (int i = 0; i < int'(w); i++) begin
      ok = 1'b0;
      for (int t = 0; t < 4000; t++) begin
        if (rsp_valid === 1'b1) begin ok = 1'b1; break; end
        @(negedge HCLK);
      end
      chk($sformatf("rsp_valid_w%0d", i), 64'(ok), 64'd1);
      if (!ok) break;
      if (i == int'(stall_w)) begin
        held = rsp_data;
        ok = 1'b1;
        for (int k = 0; k < int'(stall_n); k++) begin
          @(negedge HCLK);
          if (PSEL !== 1'b0 || rsp_data !== held || rsp_valid !== 1'b1) ok = 1'b0;
        end
        chk($sformatf("stall_quiet_w%0d", i), 64'(ok), 64'd1);
      end
      chk($sformatf("rsp_data_w%0d", i), 64'(rsp_data), 64'(ed[i]));
      chk($sformatf("rsp_last_w%0d", i), 64'(rsp_last), 64'(i == int'(w) - 1));
      rsp_ready = 1'b1;
      @(negedge HCLK);
      rsp_ready = 1'b0;
    end

    for (int t = 0; t < 50 && req_ready !== 1'b1; t++) @(negedge HCLK);
    chk("ready_after_done", 64'(req_ready), 64'd1);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("apb_count", 64'(log_q.size() - base_log), 64'(exp_q.size()));
    for (int j = 0; j < exp_q.size(); j++)
      if (base_log + j < log_q.size())
        chk($sformatf("apb_%0d", j), 64'(log_q[base_log + j]), 64'(exp_q[j]));
    chk("apb_stable", 64'(unstable), 64'd0);
  endtask

  localparam int unsigned NONE = 32'hFFFF;

  initial begin
    int unsigned base;
    bit          found;
    bit          quiet;
    HRESET = 1'b1; req_valid = 1'b0; req_addr = '0; req_words = '0; req_clkdiv = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge HCLK);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_penable", 64'(PENABLE), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_last", 64'(rsp_last), 64'd0);
    HRESET = 1'b0;
    @(negedge HCLK);

    // Single word, fixed values.
    run_req(24'h001000, 1, 8'd4, 0, 0, NONE, 0, 1'b1, 32'hDEADBEEF);
    // Four words with three PREADY wait cycles on every access.
    run_req(24'($urandom), 4, 8'd2, 3, 0, NONE, 0, 1'b0, '0);
    // Back-pressure for 10 cycles on the second word.
    run_req(24'($urandom), 3, 8'd1, 1, 0, 1, 10, 1'b0, '0);
    // Five empty polls before data.
    run_req(24'($urandom), 1, 8'd7, 0, 5, NONE, 0, 1'b0, '0);

    // Reset during the SPIADR ACCESS phase.
    wait_cfg = 3;
    start_req(24'h0ABCDE, 11'd2, 8'd3);
    found = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (PSEL === 1'b1 && PENABLE === 1'b1 && PADDR === 12'h00C) begin found = 1'b1; break; end
      @(negedge HCLK);
    end
    chk("reach_wr_adr_access", 64'(found), 64'd1);
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    chk("midrst_psel", 64'(PSEL), 64'd0);
    chk("midrst_penable", 64'(PENABLE), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    run_req(24'($urandom), 2, 8'd5, 2, 1, NONE, 0, 1'b0, '0);

    // Zero-word request: accepted and retired with no traffic.
    base = log_q.size();
    start_req(24'h123456, 11'd0, 8'd1);
    chk("zero_req_ready", 64'(req_ready), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    quiet = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (PSEL !== 1'b0 || rsp_valid !== 1'b0) quiet = 1'b0;
      @(negedge HCLK);
    end
    chk("zero_quiet", 64'(quiet), 64'd1);
    chk("zero_no_apb", 64'(log_q.size() - base), 64'd0);

    // Randomized requests.
    for (int r = 0; r < 6; r++) begin
      run_req(24'($urandom), $urandom_range(1, 5), 8'($urandom),
              $urandom_range(0, 2), $urandom_range(0, 3),
              $urandom_range(0, 5), $urandom_range(0, 6), 1'b0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
